// File: rtl/osc_bank.sv
`default_nettype none
// ============================================================================
// Module   : osc_bank
// Brief    : Multi-voice square-wave oscillator bank with registered amplitude mixer.
// Revision : 1.0 - initial release
// ============================================================================
module osc_bank #(
    parameter int NUM_VOICES = 4,
    parameter int CNT_W      = 19,
    parameter int AMP_W      = 8,
    parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    parameter int MIX_W      = AMP_W + $clog2(NUM_VOICES + 1)
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        cfg_we,
    input  logic [IDX_W-1:0]            cfg_voice,
    input  logic [CNT_W-1:0]            cfg_max,
    input  logic [AMP_W-1:0]            cfg_amp,
    input  logic                        cfg_en,
    input  logic                        sync,
    output logic [NUM_VOICES*CNT_W-1:0] count,
    output logic [NUM_VOICES-1:0]       wave,
    output logic [NUM_VOICES-1:0]       tick,
    output logic [MIX_W-1:0]            mix
);

    logic [NUM_VOICES*AMP_W-1:0] w_amp_all;
    logic [NUM_VOICES-1:0]       w_active;
    logic [MIX_W-1:0]            w_sum;
    logic [MIX_W-1:0]            r_mix;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        logic [CNT_W-1:0] r_max;
        logic [CNT_W-1:0] r_count;
        logic [AMP_W-1:0] r_amp;
        logic             r_en;
        logic             r_wave;
        logic             r_tick;
        logic             w_wr;
        logic             w_restart;
        logic             w_wrap;

        // Out-of-range indices never match any voice, so such writes are dropped.
        assign w_wr      = cfg_we && (cfg_voice == IDX_W'(i));
        assign w_restart = w_wr || sync;
        assign w_wrap    = (r_count == r_max);

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                r_max   <= '0;
                r_amp   <= '0;
                r_en    <= 1'b0;
                r_count <= '0;
                r_wave  <= 1'b0;
                r_tick  <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_max <= cfg_max;
                    r_amp <= cfg_amp;
                    r_en  <= cfg_en;
                end
                if (w_restart || !r_en) begin
                    r_count <= '0;
                    r_wave  <= 1'b0;
                    r_tick  <= 1'b0;
                end else if (w_wrap) begin
                    r_count <= '0;
                    r_wave  <= ~r_wave;
                    r_tick  <= 1'b1;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                    r_tick  <= 1'b0;
                end
            end
        end

        assign count[i*CNT_W +: CNT_W]     = r_count;
        assign wave[i]                     = r_wave;
        assign tick[i]                     = r_tick;
        assign w_amp_all[i*AMP_W +: AMP_W] = r_amp;
        assign w_active[i]                 = r_wave & r_en;
    end

    // MIX_W is sized so the full sum of all amplitudes always fits.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_active[i]) begin
                w_sum = w_sum + MIX_W'(w_amp_all[i*AMP_W +: AMP_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mix <= '0;
        end else begin
            r_mix <= w_sum;
        end
    end

    assign mix = r_mix;

endmodule
`default_nettype wire

// File: tb/tb_osc_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_osc_bank
// Brief    : Scoreboard testbench for osc_bank with directed stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_osc_bank;

    localparam int NV   = 4;
    localparam int CW   = 19;
    localparam int MAXT = 24999;

    logic        clk       = 1'b0;
    logic        nrst      = 1'b1;
    logic        cfg_we    = 1'b0;
    logic [1:0]  cfg_voice = '0;
    logic [18:0] cfg_max   = '0;
    logic [7:0]  cfg_amp   = '0;
    logic        cfg_en    = 1'b0;
    logic        sync      = 1'b0;
    logic [75:0] count;
    logic [3:0]  wave;
    logic [3:0]  tick;
    logic [10:0] mix;

    // Small three-voice instance: index 3 is representable but out of range.
    logic        we5    = 1'b0;
    logic [1:0]  voice5 = '0;
    logic [3:0]  max5   = '0;
    logic [3:0]  amp5   = '0;
    logic        en5    = 1'b0;
    logic        sync5  = 1'b0;
    logic [11:0] count5;
    logic [2:0]  wave5;
    logic [2:0]  tick5;
    logic [5:0]  mix5;

    osc_bank u_dut (
        .clk       (clk),
        .nrst      (nrst),
        .cfg_we    (cfg_we),
        .cfg_voice (cfg_voice),
        .cfg_max   (cfg_max),
        .cfg_amp   (cfg_amp),
        .cfg_en    (cfg_en),
        .sync      (sync),
        .count     (count),
        .wave      (wave),
        .tick      (tick),
        .mix       (mix)
    );

    osc_bank #(.NUM_VOICES(3), .CNT_W(4), .AMP_W(4)) u_dut5 (
        .clk       (clk),
        .nrst      (nrst),
        .cfg_we    (we5),
        .cfg_voice (voice5),
        .cfg_max   (max5),
        .cfg_amp   (amp5),
        .cfg_en    (en5),
        .sync      (sync5),
        .count     (count5),
        .wave      (wave5),
        .tick      (tick5),
        .mix       (mix5)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [75:0] cnt;
        logic [3:0]  wv;
        logic [3:0]  tk;
        logic [10:0] mx;
        bit          hv;
        int          hcnt;
        int          hw;
        int          ht;
        int          hmix;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   seen30 = 1'b0;

    int m_max[NV];
    int m_amp[NV];
    int m_cnt[NV];
    bit m_en[NV];
    bit m_wave[NV];
    bit m_tick[NV];
    int m_mix;

    int h_cnt[12]  = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    int h_wave[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    int h_tick[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    int h_mix[12]  = '{0, 0, 0, 0, 0, 10, 10, 10, 10, 0, 0, 0};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int v = 0; v < NV; v++) begin
            m_max[v] = 0; m_amp[v] = 0; m_cnt[v] = 0;
            m_en[v] = 0; m_wave[v] = 0; m_tick[v] = 0;
        end
        m_mix = 0;
    endtask

    // Drive one cycle of stimulus, advance the reference model, queue the expectation.
    task automatic step(input bit we, input int voice, input int mx, input int amp,
                        input bit en, input bit sy, input bit hv, input int hc,
                        input int hw, input int ht, input int hm);
        exp_t e;
        int   nmix;
        @(negedge clk);
        cfg_we    = we;
        cfg_voice = 2'(voice);
        cfg_max   = 19'(mx);
        cfg_amp   = 8'(amp);
        cfg_en    = en;
        sync      = sy;
        nmix = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_wave[v] && m_en[v]) nmix += m_amp[v];
        end
        for (int v = 0; v < NV; v++) begin
            bit wr;
            wr = we && (voice == v);
            if (wr) begin
                m_max[v] = mx; m_amp[v] = amp; m_en[v] = en;
            end
            if (wr || sy || !m_en[v]) begin
                m_cnt[v] = 0; m_wave[v] = 0; m_tick[v] = 0;
            end else if (m_cnt[v] == m_max[v]) begin
                m_cnt[v] = 0; m_wave[v] = ~m_wave[v]; m_tick[v] = 1;
            end else begin
                m_cnt[v] = m_cnt[v] + 1; m_tick[v] = 0;
            end
        end
        m_mix = nmix;
        for (int v = 0; v < NV; v++) begin
            e.cnt[v*CW +: CW] = 19'(m_cnt[v]);
            e.wv[v] = m_wave[v];
            e.tk[v] = m_tick[v];
        end
        e.mx = 11'(m_mix);
        e.hv = hv; e.hcnt = hc; e.hw = hw; e.ht = ht; e.hmix = hm;
        q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("count", count, e.cnt);
            chk("wave", wave, e.wv);
            chk("tick", tick, e.tk);
            chk("mix", mix, e.mx);
            if (mix == 11'd30) seen30 = 1'b1;
            if (e.hv) begin
                chk("hand_count0", count[18:0], e.hcnt);
                chk("hand_wave0", wave[0], e.hw);
                chk("hand_tick0", tick[0], e.ht);
                if (e.hmix >= 0) chk("hand_mix", mix, e.hmix);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        m_reset();
        #1 nrst = 1'b0;
        #2;
        chk("reset_count", count, 76'd0);
        chk("reset_wave", wave, 4'd0);
        chk("reset_tick", tick, 4'd0);
        chk("reset_mix", mix, 11'd0);
        chk("reset_count5", count5, 12'd0);
        @(negedge clk) nrst = 1'b1;

        // Single voice, period 8
        step(1, 0, 3, 10, 1, 0, 1, h_cnt[0], h_wave[0], h_tick[0], h_mix[0]);
        for (int k = 1; k < 12; k++) step(0, 0, 0, 0, 0, 0, 1, h_cnt[k], h_wave[k], h_tick[k], h_mix[k]);

        // Two voices mixed
        step(1, 1, 1, 20, 1, 0, 0, 0, 0, 0, -1);
        for (int k = 0; k < 64; k++) idle();
        @(posedge clk); #2;
        chk("mix_reaches_30", seen30, 1'b1);

        // max=0 voice, then out-of-range write on the three-voice instance
        step(1, 2, 0, 5, 1, 0, 0, 0, 0, 0, -1);
        for (int k = 0; k < 8; k++) idle();
        idle(); we5 = 1'b1; voice5 = 2'd0; max5 = 4'd1; amp5 = 4'd3; en5 = 1'b1;
        @(posedge clk); #2;
        chk("v5_e0_count", count5, 12'h000);
        idle(); we5 = 1'b1; voice5 = 2'd3; max5 = 4'd0; amp5 = 4'd15; en5 = 1'b1;
        @(posedge clk); #2;
        chk("v5_e1_count", count5, 12'h001);
        chk("v5_e1_wave", wave5, 3'b000);
        idle(); we5 = 1'b0;
        @(posedge clk); #2;
        chk("v5_e2_count", count5, 12'h000);
        chk("v5_e2_wave", wave5, 3'b001);
        chk("v5_e2_tick", tick5, 3'b001);
        idle();
        @(posedge clk); #2;
        chk("v5_e3_count", count5, 12'h001);
        chk("v5_e3_mix", mix5, 6'd3);

        // Out-of-phase voices, then sync
        step(1, 1, 3, 20, 1, 0, 0, 0, 0, 0, -1);
        for (int k = 0; k < 5; k++) idle();
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, -1);
        for (int k = 0; k < 16; k++) idle();

        // Mid-count rewrite, then sync together with a write
        step(1, 0, 7, 10, 1, 0, 0, 0, 0, 0, -1);
        idle();
        step(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, -1);
        step(1, 0, 2, 10, 1, 0, 1, 0, 0, 0, -1);
        for (int k = 0; k < 12; k++) idle();
        step(1, 3, 5, 7, 1, 1, 1, 0, 0, 0, -1);
        for (int k = 0; k < 10; k++) idle();

        // Asynchronous reset between edges
        @(negedge clk); cfg_we = 1'b0; sync = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("async_rst_count", count, 76'd0);
        chk("async_rst_wave", wave, 4'd0);
        chk("async_rst_tick", tick, 4'd0);
        chk("async_rst_mix", mix, 11'd0);
        m_reset();
        @(negedge clk) nrst = 1'b1;

        // Long half-period: first tick after MAXT+1 enabled cycles
        step(1, 0, MAXT, 1, 1, 0, 1, 0, 0, 0, 0);
        first = 0;
        for (int k = 1; k <= MAXT + 5 && first == 0; k++) begin
            idle();
            @(posedge clk); #2;
            if (tick[0]) first = k;
        end
        chk("first_tick_cycle", first, MAXT + 1);

        @(posedge clk); #3;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
